// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Segment codes, FSM state encoding and BCD digit lookup shared by
//            the seg7 formatter blocks.
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam logic [7:0]  SEG_BLANK   = 8'hFF;
    localparam logic [7:0]  SEG_MINUS   = 8'hBF;
    localparam logic [7:0]  SEG_ZERO    = 8'hC0;
    localparam logic [63:0] SEG_OVF_ALL = {8{SEG_MINUS}};

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_CONVERT  = 2'd1;
    localparam logic [1:0]  ST_ENCODE   = 2'd2;

    // Active-low segments {dp,g,f,e,d,c,b,a}; non-BCD codes show blank.
    function automatic logic [7:0] seg_lut(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_digit_enc.sv
`default_nettype none
// ============================================================================
// Module   : seg7_digit_enc
// Brief    : Combinational BCD digit to active-low 7-segment code.
// Revision : 1.0  initial release
// ============================================================================
module seg7_digit_enc
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [7:0] o_seg
);

    assign o_seg = seg_lut(i_bcd);

endmodule
`default_nettype wire

// File: rtl/seg7_dec_fmt.sv
`default_nettype none
// ============================================================================
// Module   : seg7_dec_fmt
// Brief    : Sequential double-dabble formatter producing 8 pre-encoded
//            7-segment digits with sign, blanking and overflow display.
// Revision : 1.0  initial release
// ============================================================================
module seg7_dec_fmt
    import seg7_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_value,
    input  logic        i_signed,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_data,
    output logic        o_disp_mode
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [4:0]  r_cnt;
    logic [71:0] r_sr;
    logic        r_neg;
    logic        r_done;
    logic [63:0] r_data;

    logic        w_neg;
    logic [31:0] w_mag;
    logic [39:0] w_bcd_adj;
    logic [71:0] w_shift;
    logic [3:0]  w_msd;
    logic        w_ovf;
    logic [63:0] w_enc;
    logic [63:0] w_fmt;

    assign w_neg = i_signed & i_value[31];
    assign w_mag = w_neg ? (~i_value + 32'd1) : i_value;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_sr[32+4*gi +: 4] >= 4'd5) ?
                                          r_sr[32+4*gi +: 4] + 4'd3 :
                                          r_sr[32+4*gi +: 4];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_enc
            seg7_digit_enc u_enc (
                .i_bcd (r_sr[32+4*gi +: 4]),
                .o_seg (w_enc[8*gi +: 8])
            );
        end
    endgenerate

    assign w_shift = {w_bcd_adj, r_sr[31:0]};

    // Most significant nonzero digit; 0 when the whole value is zero.
    always_comb begin
        w_msd = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_sr[32+4*i +: 4] != 4'd0) begin
                w_msd = 4'(i);
            end
        end
    end

    assign w_ovf = (r_sr[71:64] != 8'd0) || (r_neg && (w_msd == 4'd7));

    always_comb begin
        w_fmt = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) <= w_msd) begin
                w_fmt[8*i +: 8] = w_enc[8*i +: 8];
            end else if (r_neg && (4'(i) == w_msd + 4'd1)) begin
                w_fmt[8*i +: 8] = SEG_MINUS;
            end else begin
                w_fmt[8*i +: 8] = BLANK_LZ ? SEG_BLANK : SEG_ZERO;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_state_next = ST_CONVERT;
            ST_CONVERT: if (r_cnt == 5'd31) w_state_next = ST_ENCODE;
            ST_ENCODE:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_sr    <= 72'd0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= {8{SEG_BLANK}};
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_neg <= w_neg;
                        r_sr  <= {40'd0, w_mag};
                        r_cnt <= 5'd0;
                    end
                end
                ST_CONVERT: begin
                    r_sr  <= w_shift << 1;
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_ENCODE: begin
                    r_data <= w_ovf ? SEG_OVF_ALL : w_fmt;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_data      = r_data;
    assign o_disp_mode = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_seg7_dec_fmt.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_dec_fmt
// Brief    : Directed self-checking bench for seg7_dec_fmt (both blanking modes).
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_dec_fmt;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] i_value = 32'd0;
    logic        i_signed = 1'b0;
    logic        i_start = 1'b0;
    logic        busy1, done1, mode1, busy0, done0, mode0;
    logic [63:0] data1, data0;

    int checks = 0;
    int errors = 0;
    int pulses, first_k, second_k;

    always #5 clk = ~clk;

    seg7_dec_fmt #(.BLANK_LZ(1'b1)) u_dut_lz1 (
        .clk(clk), .rstn(rstn), .i_value(i_value), .i_signed(i_signed), .i_start(i_start),
        .o_busy(busy1), .o_done(done1), .o_data(data1), .o_disp_mode(mode1)
    );

    seg7_dec_fmt #(.BLANK_LZ(1'b0)) u_dut_lz0 (
        .clk(clk), .rstn(rstn), .i_value(i_value), .i_signed(i_signed), .i_start(i_start),
        .o_busy(busy0), .o_done(done0), .o_data(data0), .o_disp_mode(mode0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start edge counts as edge 1, so done shows up 33 samples after it.
    task automatic run(input string tag, input logic [31:0] v, input logic s,
                       input logic [63:0] exp1);
        int n;
        i_value  = v;
        i_signed = s;
        i_start  = 1'b1;
        step();
        i_start  = 1'b0;
        i_value  = 32'hDEAD_BEEF;
        i_signed = ~s;
        chk({tag, " busy"}, {63'd0, busy1}, 64'd1);
        n = 0;
        while (!done1 && n < 100) begin
            step();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd33);
        chk({tag, " busy at done"}, {63'd0, busy1}, 64'd0);
        chk({tag, " data"}, data1, exp1);
        step();
        chk({tag, " done pulse"}, {63'd0, done1}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        repeat (3) step();
        chk("reset busy", {63'd0, busy1}, 64'd0);
        chk("reset done", {63'd0, done1}, 64'd0);
        chk("reset data", data1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("reset mode", {62'd0, mode1, mode0}, 64'd3);
        rstn = 1'b1;
        step();

        run("zero", 32'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0);
        chk("zero lz0", data0, 64'hC0C0_C0C0_C0C0_C0C0);
        run("12345678", 32'd12345678, 1'b0, 64'hF9A4_B099_9282_F880);
        run("neg5", 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_BF92);
        run("neg1", 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_BFF9);
        run("ovf 1e8", 32'd100000000, 1'b0, 64'hBFBF_BFBF_BFBF_BFBF);
        run("ovf umax", 32'hFFFF_FFFF, 1'b0, 64'hBFBF_BFBF_BFBF_BFBF);
        run("ovf neg8e7", -32'sd80000000, 1'b1, 64'hBFBF_BFBF_BFBF_BFBF);
        run("neg9999999", -32'sd9999999, 1'b1, 64'hBF90_9090_9090_9090);
        run("42", 32'd42, 1'b0, 64'hFFFF_FFFF_FFFF_99A4);
        chk("42 lz0", data0, 64'hC0C0_C0C0_C0C0_99A4);

        // i_start held high: accepted at start, then again in the done cycle.
        i_value  = 32'd7;
        i_signed = 1'b0;
        i_start  = 1'b1;
        step();
        pulses   = 0;
        first_k  = -1;
        second_k = -1;
        for (int k = 1; k <= 90; k++) begin
            step();
            if (k == 40) i_start = 1'b0;
            if (done1) begin
                pulses++;
                if (first_k < 0) first_k = k;
                else second_k = k;
            end
            if (k == 34) chk("held re-accept busy", {63'd0, busy1}, 64'd1);
        end
        chk("held pulses", 64'(pulses), 64'd2);
        chk("held first done", 64'(first_k), 64'd33);
        chk("held second done", 64'(second_k), 64'd67);
        chk("held data", data1, 64'hFFFF_FFFF_FFFF_FFF8);

        // Reset in the middle of a conversion aborts it.
        i_value = 32'd12345678;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (10) step();
        chk("abort pre busy", {63'd0, busy1}, 64'd1);
        rstn = 1'b0;
        step();
        chk("abort busy", {63'd0, busy1}, 64'd0);
        chk("abort done", {63'd0, done1}, 64'd0);
        chk("abort data", data1, 64'hFFFF_FFFF_FFFF_FFFF);
        rstn = 1'b1;
        pulses = 0;
        repeat (40) begin
            step();
            if (done1) pulses++;
        end
        chk("abort no done", 64'(pulses), 64'd0);
        run("after abort", 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_BF92);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
